// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: the state encoding and
// the default timing constants for the 100 MHz front-panel clock.
package button_event_decoder_pkg;

    // FSM state encoding, kept as plain constants for legacy tools
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRESS1   = 3'd1;
    localparam logic [2:0] ST_WAIT2    = 3'd2;
    localparam logic [2:0] ST_WAIT_REL = 3'd3;
    localparam logic [2:0] ST_HELD     = 3'd4;

    // Board clock and the default press timings derived from it
    localparam int CLK_HZ                = 100_000_000;
    localparam int DEFAULT_LONG_CYCLES   = CLK_HZ;          // 1 s
    localparam int DEFAULT_GAP_CYCLES    = (CLK_HZ / 10) * 3; // 300 ms
    localparam int DEFAULT_REPEAT_CYCLES = CLK_HZ / 5;      // 200 ms
    localparam int DEFAULT_CNT_W         = 27;

endpackage

// File: rtl/button_event_decoder_if.sv
// Bundle of the debounced button level and the one-cycle event pulses.
// The decoder sits on the slave side; whoever drives the button level and
// consumes the events uses the master side.
interface button_event_decoder_if;

    logic btn_level;
    logic short_press;
    logic double_press;
    logic long_press;
    logic repeat_tick;

    modport master (
        output btn_level,
        input  short_press,
        input  double_press,
        input  long_press,
        input  repeat_tick
    );

    modport slave (
        input  btn_level,
        output short_press,
        output double_press,
        output long_press,
        output repeat_tick
    );

endinterface

// File: rtl/button_event_decoder.sv
// Turns a clean button level into one-cycle event pulses: short press,
// double press, long press and auto-repeat while held after a long press.
// A button still held when reset is released must be let go before it can
// start a new press, which is why the previous-level flop resets to 1.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter int GAP_CYCLES    = DEFAULT_GAP_CYCLES,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    button_event_decoder_if.slave bus
);

    // Terminal counts, compared before the counter could ever wrap
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q;
    logic             short_press_q, short_press_d;
    logic             double_press_q, double_press_d;
    logic             long_press_q, long_press_d;
    logic             repeat_tick_q, repeat_tick_d;
    logic             rise;

    assign rise = bus.btn_level & ~btn_q;

    // Next-state, counter and event-pulse decisions for the current sample
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        short_press_d  = 1'b0;
        double_press_d = 1'b0;
        long_press_d   = 1'b0;
        repeat_tick_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESS1;
                    cnt_d   = CNT_ONE;
                end
            end

            ST_PRESS1: begin
                if (bus.btn_level) begin
                    if (cnt_q == LONG_LAST) begin
                        long_press_d = 1'b1;
                        state_d      = ST_HELD;
                        cnt_d        = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_WAIT2;
                    cnt_d   = CNT_ONE;
                end
            end

            ST_WAIT2: begin
                if (bus.btn_level) begin
                    double_press_d = 1'b1;
                    state_d        = ST_WAIT_REL;
                    cnt_d          = CNT_ZERO;
                end else if (cnt_q == GAP_LAST) begin
                    short_press_d = 1'b1;
                    state_d       = ST_IDLE;
                    cnt_d         = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_WAIT_REL: begin
                if (!bus.btn_level) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end

            ST_HELD: begin
                if (!bus.btn_level) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_tick_d = 1'b1;
                    cnt_d         = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, previous level and registered event outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            cnt_q          <= CNT_ZERO;
            btn_q          <= 1'b1;
            short_press_q  <= 1'b0;
            double_press_q <= 1'b0;
            long_press_q   <= 1'b0;
            repeat_tick_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            btn_q          <= bus.btn_level;
            short_press_q  <= short_press_d;
            double_press_q <= double_press_d;
            long_press_q   <= long_press_d;
            repeat_tick_q  <= repeat_tick_d;
        end
    end

    assign bus.short_press  = short_press_q;
    assign bus.double_press = double_press_q;
    assign bus.long_press   = long_press_q;
    assign bus.repeat_tick  = repeat_tick_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder with small timing values.
// A run-length reference model predicts the event for every sample; directed
// scenarios also tally the events they produce against fixed counts.
module tb_button_event_decoder;

    localparam int LONG = 8;
    localparam int GAP  = 4;
    localparam int REP  = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    button_event_decoder_if bus ();

    button_event_decoder #(
        .LONG_CYCLES   (LONG),
        .GAP_CYCLES    (GAP),
        .REPEAT_CYCLES (REP),
        .CNT_W         (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int tally [4];

    // Reference model state: previous level, length of the current run and
    // the role of that run (0 ignored, 1 first press, 2 gap after a short press)
    logic model_prev;
    int   model_run;
    int   model_role;

    // Event vectors are {short, double, long, repeat}
    task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] observed();
        return {bus.short_press, bus.double_press, bus.long_press, bus.repeat_tick};
    endfunction

    task modelReset();
        model_prev = 1'b1;
        model_run  = 0;
        model_role = 0;
    endtask

    // Classify one sample by run lengths: long at exactly LONG high samples,
    // repeat every REP samples beyond that, short at GAP low samples after a
    // short first press, double on a rise while that gap is still open
    task modelStep(input logic s, output logic [3:0] ev);
        ev = 4'b0000;
        if (s == model_prev) begin
            model_run++;
        end else begin
            if (s) begin
                if (model_role == 2) begin
                    ev[2] = 1'b1;
                    model_role = 0;
                end else begin
                    model_role = 1;
                end
            end else begin
                if (model_role == 1 && model_run < LONG) model_role = 2;
                else model_role = 0;
            end
            model_run = 1;
        end
        model_prev = s;
        if (model_role == 1 && s) begin
            if (model_run == LONG) ev[1] = 1'b1;
            else if (model_run > LONG && ((model_run - LONG) % REP) == 0) ev[0] = 1'b1;
        end
        if (model_role == 2 && !s && model_run == GAP) begin
            ev[3] = 1'b1;
            model_role = 0;
        end
    endtask

    task applyStimulus(input logic b, input string tag);
        logic [3:0] ev;
        logic [3:0] obs;
        bus.btn_level = b;
        modelStep(b, ev);
        @(posedge clk);
        #1;
        obs = observed();
        checkOutput(tag, {28'd0, obs}, {28'd0, ev});
        checkOutput("onehot", ($countones(obs) <= 1) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 4; i++) if (obs[i]) tally[i]++;
    endtask

    task applyRun(input logic b, input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(b, tag);
    endtask

    task clearTally();
        for (int i = 0; i < 4; i++) tally[i] = 0;
    endtask

    task checkTally(input string tag, input int s, input int d, input int l, input int r);
        checkOutput({tag, "_short"},  tally[3], s);
        checkOutput({tag, "_double"}, tally[2], d);
        checkOutput({tag, "_long"},   tally[1], l);
        checkOutput({tag, "_repeat"}, tally[0], r);
    endtask

    // Asynchronous reset mid-operation; outputs must drop at once
    task doReset(input logic b);
        bus.btn_level = b;
        resetn = 1'b0;
        #1;
        checkOutput("rst_async", {28'd0, observed()}, 32'd0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_hold", {28'd0, observed()}, 32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.btn_level = 1'b0;
        resetn = 1'b0;
        modelReset();
        clearTally();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", {28'd0, observed()}, 32'd0);
        resetn = 1'b1;
        applyRun(1'b0, 2, "settle");

        $display("[TB] short press");
        clearTally();
        applyRun(1'b1, 3, "short_hi");
        applyRun(1'b0, 6, "short_lo");
        checkTally("short", 1, 0, 0, 0);

        $display("[TB] double press");
        clearTally();
        applyRun(1'b1, 2, "dbl_hi1");
        applyRun(1'b0, 2, "dbl_lo1");
        applyRun(1'b1, 5, "dbl_hi2");
        applyRun(1'b0, 6, "dbl_lo2");
        checkTally("double", 0, 1, 0, 0);

        $display("[TB] long press with repeat");
        clearTally();
        applyRun(1'b1, 14, "long_hi");
        applyRun(1'b0, 6, "long_lo");
        checkTally("long", 0, 0, 1, 2);

        $display("[TB] long boundary");
        clearTally();
        applyRun(1'b1, 7, "lb7_hi");
        applyRun(1'b0, 6, "lb7_lo");
        checkTally("lb7", 1, 0, 0, 0);
        clearTally();
        applyRun(1'b1, 8, "lb8_hi");
        applyRun(1'b0, 6, "lb8_lo");
        checkTally("lb8", 0, 0, 1, 0);

        $display("[TB] gap boundary");
        clearTally();
        applyRun(1'b1, 2, "gb3_hi1");
        applyRun(1'b0, 3, "gb3_lo");
        applyRun(1'b1, 2, "gb3_hi2");
        applyRun(1'b0, 6, "gb3_lo2");
        checkTally("gb3", 0, 1, 0, 0);
        clearTally();
        applyRun(1'b1, 2, "gb4_hi1");
        applyRun(1'b0, 4, "gb4_lo1");
        applyRun(1'b1, 2, "gb4_hi2");
        applyRun(1'b0, 6, "gb4_lo2");
        checkTally("gb4", 2, 0, 0, 0);

        $display("[TB] reset mid press");
        clearTally();
        applyRun(1'b1, 3, "rst_pre");
        doReset(1'b1);
        applyRun(1'b1, 10, "rst_held");
        applyRun(1'b0, 1, "rst_lo1");
        applyRun(1'b1, 2, "rst_hi");
        applyRun(1'b0, 6, "rst_lo2");
        checkTally("rst_press", 1, 0, 0, 0);

        $display("[TB] reset mid gap");
        clearTally();
        applyRun(1'b1, 2, "rstg_hi");
        applyRun(1'b0, 3, "rstg_lo");
        doReset(1'b0);
        applyRun(1'b0, 6, "rstg_after");
        checkTally("rst_gap", 0, 0, 0, 0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 9) == 0) doReset(1'($urandom_range(0, 1)));
            applyRun(1'(r % 2 == 0), $urandom_range(1, 14), "random");
        end
        applyRun(1'b0, 6, "random_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
